// File: rtl/gen_ram_rden.sv
// Read-enable and row-select controller for a ping-pong pair of line RAMs.
// The RAM not being written is read so downstream sees two adjacent rows.
module gen_ram_rden #(
  parameter int IDLE_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       rama_wren,
  input  logic       ramb_wren,
  output logic [1:0] sel_row1_out,
  output logic [1:0] sel_row2_out,
  output logic       frame_end,
  output logic       rama_rden,
  output logic       ramb_rden
);

  localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

  logic             wa_s;
  logic             wb_s;
  logic             wr_s;
  logic             a_valid_d, a_valid_q;
  logic             b_valid_d, b_valid_q;
  logic             frame_active_d, frame_active_q;
  logic [CNT_W-1:0] idle_cnt_d, idle_cnt_q;
  logic [1:0]       sel_row1_d, sel_row1_q;
  logic [1:0]       sel_row2_d, sel_row2_q;
  logic             frame_end_d, frame_end_q;

  // Write qualification, read enables and next-state logic.
  always_comb begin
    wa_s           = rama_wren & ~ramb_wren;
    wb_s           = ramb_wren & ~rama_wren;
    wr_s           = wa_s | wb_s;
    rama_rden      = wb_s & a_valid_q & ~aclr;
    ramb_rden      = wa_s & b_valid_q & ~aclr;
    a_valid_d      = a_valid_q;
    b_valid_d      = b_valid_q;
    frame_active_d = frame_active_q;
    idle_cnt_d     = idle_cnt_q;
    sel_row1_d     = 2'b00;
    sel_row2_d     = 2'b00;
    frame_end_d    = 1'b0;

    if (rama_rden) begin
      sel_row1_d = 2'b01;
    end else if (ramb_rden) begin
      sel_row1_d = 2'b10;
    end else begin
      sel_row1_d = 2'b00;
    end

    if (wr_s) begin
      sel_row2_d = 2'b11;
    end else begin
      sel_row2_d = 2'b00;
    end

    // Both-wren cycles are not writes, so they age the idle counter too.
    if (wr_s) begin
      idle_cnt_d = {CNT_W{1'b0}};
    end else if (frame_active_q && (idle_cnt_q < IDLE_MAX)) begin
      idle_cnt_d = idle_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      idle_cnt_d = idle_cnt_q;
    end

    frame_end_d = ~wr_s & frame_active_q & (idle_cnt_q == IDLE_LAST);

    if (frame_end_d) begin
      frame_active_d = 1'b0;
      a_valid_d      = 1'b0;
      b_valid_d      = 1'b0;
    end else begin
      frame_active_d = frame_active_q | wr_s;
      a_valid_d      = a_valid_q | wa_s;
      b_valid_d      = b_valid_q | wb_s;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      a_valid_q      <= 1'b0;
      b_valid_q      <= 1'b0;
      frame_active_q <= 1'b0;
      idle_cnt_q     <= {CNT_W{1'b0}};
      sel_row1_q     <= 2'b00;
      sel_row2_q     <= 2'b00;
      frame_end_q    <= 1'b0;
    end else begin
      a_valid_q      <= a_valid_d;
      b_valid_q      <= b_valid_d;
      frame_active_q <= frame_active_d;
      idle_cnt_q     <= idle_cnt_d;
      sel_row1_q     <= sel_row1_d;
      sel_row2_q     <= sel_row2_d;
      frame_end_q    <= frame_end_d;
    end
  end

  assign sel_row1_out = sel_row1_q;
  assign sel_row2_out = sel_row2_q;
  assign frame_end    = frame_end_q;

endmodule

// File: tb/tb_gen_ram_rden.sv
// Scoreboard bench for gen_ram_rden: a cycle model pushes expectations,
// which are popped and compared against the DUT each cycle.
module tb_gen_ram_rden;

  localparam int IDLE = 16;

  logic       clk = 1'b0;
  logic       aclr;
  logic       rama_wren;
  logic       ramb_wren;
  logic [1:0] sel_row1_out;
  logic [1:0] sel_row2_out;
  logic       frame_end;
  logic       rama_rden;
  logic       ramb_rden;

  gen_ram_rden #(.IDLE_CYCLES(IDLE), .CNT_W(8)) dut (
    .clk          (clk),
    .aclr         (aclr),
    .rama_wren    (rama_wren),
    .ramb_wren    (ramb_wren),
    .sel_row1_out (sel_row1_out),
    .sel_row2_out (sel_row2_out),
    .frame_end    (frame_end),
    .rama_rden    (rama_rden),
    .ramb_rden    (ramb_rden)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ra;
    logic       rb;
    logic [1:0] s1;
    logic [1:0] s2;
    logic       fe;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // model state
  logic m_av = 1'b0;
  logic m_bv = 1'b0;
  logic m_fa = 1'b0;
  int   m_cnt = 0;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_av  = 1'b0;
    m_bv  = 1'b0;
    m_fa  = 1'b0;
    m_cnt = 0;
  endtask

  // Drive one cycle of wren, predict, then compare comb and registered outputs.
  task automatic step(input logic a, input logic b);
    logic wa, wb, w;
    exp_t e;
    rama_wren = a;
    ramb_wren = b;
    wa = a & ~b;
    wb = b & ~a;
    w  = wa | wb;
    e.ra = wb & m_av;
    e.rb = wa & m_bv;
    e.s1 = e.ra ? 2'b01 : (e.rb ? 2'b10 : 2'b00);
    e.s2 = w ? 2'b11 : 2'b00;
    e.fe = !w && m_fa && (m_cnt == IDLE - 1);
    q.push_back(e);
    if (w) m_cnt = 0;
    else if (m_fa && m_cnt < IDLE) m_cnt++;
    if (e.fe) begin
      m_fa = 1'b0;
      m_av = 1'b0;
      m_bv = 1'b0;
    end else begin
      if (w) m_fa = 1'b1;
      if (wa) m_av = 1'b1;
      if (wb) m_bv = 1'b1;
    end

    @(negedge clk);
    if (q.size() == 0) begin
      check_eq("queue_empty", 8'd1, 8'd0);
    end else begin
      e = q.pop_front();
      check_eq("rama_rden", {7'd0, rama_rden}, {7'd0, e.ra});
      check_eq("ramb_rden", {7'd0, ramb_rden}, {7'd0, e.rb});
      check_eq("rden_excl", {7'd0, rama_rden & ramb_rden}, 8'd0);
      @(posedge clk);
      #1;
      check_eq("sel_row1", {6'd0, sel_row1_out}, {6'd0, e.s1});
      check_eq("sel_row2", {6'd0, sel_row2_out}, {6'd0, e.s2});
      check_eq("frame_end", {7'd0, frame_end}, {7'd0, e.fe});
    end
  endtask

  task automatic row(input logic is_a, input int len);
    for (int i = 0; i < len; i++) step(is_a, ~is_a);
  endtask

  task automatic idle(input int len);
    for (int i = 0; i < len; i++) step(1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rama_rden"}, {7'd0, rama_rden}, 8'd0);
    check_eq({tag, "_ramb_rden"}, {7'd0, ramb_rden}, 8'd0);
    check_eq({tag, "_sel1"}, {6'd0, sel_row1_out}, 8'd0);
    check_eq({tag, "_sel2"}, {6'd0, sel_row2_out}, 8'd0);
    check_eq({tag, "_fe"}, {7'd0, frame_end}, 8'd0);
  endtask

  initial begin
    aclr      = 1'b1;
    rama_wren = 1'b0;
    ramb_wren = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    aclr = 1'b0;

    // first A row, first B row, then eight more alternating rows
    row(1'b1, 12);
    row(1'b0, 12);
    for (int r = 0; r < 8; r++) row((r % 2) == 0, 12);

    // idle long enough for one frame_end; valids then cleared
    idle(20);
    row(1'b1, 12);
    row(1'b0, 12);

    // short gap keeps the frame alive
    idle(10);
    row(1'b1, 12);

    // illegal both-high cycles mid-frame, then B row
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    row(1'b0, 6);

    // asynchronous reset mid-row (rama_rden is high here)
    rama_wren = 1'b0;
    ramb_wren = 1'b1;
    #1;
    check_eq("pre_reset_rama_rden", {7'd0, rama_rden}, 8'd1);
    aclr = 1'b1;
    #1;
    check_reset_outputs("midrow");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("midrow_hold");
    aclr = 1'b0;

    // continuing B row is now the first row of a frame
    row(1'b0, 12);
    row(1'b1, 12);
    row(1'b0, 4);
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gen_ram_rden.md
Name: gen_ram_rden

Overview:
- Read-enable and row-select controller for a two-line-buffer CCD/Bayer front end.
- Incoming rows are written alternately into line RAM A and line RAM B.
- While one RAM is being written, this block reads the previously stored row from the other RAM, so downstream logic receives two vertically adjacent rows.
- It tells the datapath which source feeds the upper and lower rows, and flags end of frame after an idle gap.

Parameters:
- IDLE_CYCLES, 16: consecutive cycles with no write (after at least one row) that declare end of frame.
- CNT_W, 8: width of the idle counter; must hold IDLE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- aclr  input  1  reset, asynchronous, active-high.
- rama_wren  input  1  RAM A is being written with the live row; high for a whole row.
- ramb_wren  input  1  RAM B is being written with the live row.
- sel_row1_out  output  2  upper (older) row source: 00 none, 01 RAM A, 10 RAM B, 11 reserved.
- sel_row2_out  output  2  lower (current) row source: 00 none, 11 live input.
- frame_end  output  1  one-cycle end-of-frame pulse.
- rama_rden  output  1  read enable for RAM A.
- ramb_rden  output  1  read enable for RAM B.

Behaviour:
- Reset (aclr=1, asynchronous):
  - a_valid=0, b_valid=0, idle counter=0, frame_active=0.
  - sel_row1_out=00, sel_row2_out=00, frame_end=0.
  - rama_rden=0 and ramb_rden=0 while aclr is high.
- Write qualification:
  - wa = rama_wren & ~ramb_wren.
  - wb = ramb_wren & ~rama_wren.
  - Both high is illegal and treated as no write (wa=wb=0). It leaves the valid flags unchanged, asserts no rden, and counts as an idle cycle.
- Valid flags:
  - a_valid sets on the first clock edge where wa=1.
  - b_valid sets on the first clock edge where wb=1.
  - Both clear on frame_end or reset.
- Read enables (combinational, zero latency):
  - rama_rden = wb & a_valid.
  - ramb_rden = wa & b_valid.
  - Each falls in the same cycle its wren falls.
  - The first row of each frame produces no read enable.
- Row selects (registered, 1-cycle latency matching the synchronous RAM read):
  - sel_row1_out <= 01 if rama_rden, 10 if ramb_rden, else 00.
  - sel_row2_out <= 11 if (wa|wb), else 00.
  - Both return to 00 one cycle after writing stops.
- frame_active sets on any wa/wb.
- Idle counter:
  - Resets to 0 on any cycle with wa|wb.
  - Otherwise, while frame_active=1, increments up to IDLE_CYCLES and saturates there.
- frame_end:
  - Registered one-cycle pulse on the edge where the idle counter reaches IDLE_CYCLES-1 → IDLE_CYCLES with frame_active=1.
  - On that same edge it clears frame_active, a_valid and b_valid.
  - No further pulse until a new write occurs.
- Gaps shorter than IDLE_CYCLES do not end the frame; the valid flags are retained.
- Back-to-back rows with zero gap are supported; wren switches A→B on a single edge.
- Reset mid-row: all outputs return to reset values immediately. After release, the next row is treated as the first row of a frame.

Test Plan:
- Reset 5 cycles, then rama_wren=1 for 12 cycles → rama_rden=ramb_rden=0 throughout; sel_row2_out=11 from cycle 2 to cycle 13 after start; sel_row1_out=00.
- Continue ramb_wren=1 for 12 cycles → rama_rden=1 for exactly those 12 cycles; sel_row1_out=01 and sel_row2_out=11 one cycle later for 12 cycles.
- Alternate A/B rows, 12 cycles each, for 10 rows → rows 2–10 alternate rama_rden/ramb_rden, each 12 cycles; the two rdens are never both high; sel_row1_out alternates 01/10.
- After the 10th row, both wren=0 for 20 cycles → exactly one frame_end pulse, 16 cycles after the last write cycle. A new A row then gives ramb_rden=0 (valid cleared); the next B row gives rama_rden=1.
- Idle gap of 10 cycles between rows (less than IDLE_CYCLES) → no frame_end; the next row's opposite rden asserts.
- Both wren=1 for 3 cycles mid-frame → both rden=0, sel_row2_out=00; idle counter advances. Also assert aclr mid-row → all outputs 0 immediately.
